// File: rtl/compare_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
// State encoding, result flag encoding ({gt,eq,lt}) and digit-count helper.
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result flags packed as {gt, eq, lt}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one DIGIT-wide slice pair.
// Zero latency; no flow control.
module digit_compare #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             x_gt,
    output logic             x_lt
);

    assign x_gt = (x > y);
    assign x_lt = (x < y);

endmodule

// File: rtl/serial_compare.sv
// MSB-first digit-serial signed/unsigned comparator with start/done handshake.
// Latency 1..NDIG cycles (early exit); start is ignored (not queued) while busy or in DONE.
module serial_compare
    import compare_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NDIG - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
            $fatal(1, "serial_compare: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [IDXW-1:0]  idx, idx_nxt;
    logic [WIDTH-1:0] op_a, op_b, op_a_nxt, op_b_nxt;
    logic [2:0]       res, res_nxt;
    logic [DIGIT-1:0] dig_a, dig_b;
    logic             dig_gt, dig_lt;

    assign dig_a = op_a[idx*DIGIT +: DIGIT];
    assign dig_b = op_b[idx*DIGIT +: DIGIT];

    digit_compare #(.DIGIT(DIGIT)) u_digit (
        .x    (dig_a),
        .y    (dig_b),
        .x_gt (dig_gt),
        .x_lt (dig_lt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= IDX_TOP;
            op_a  <= '0;
            op_b  <= '0;
            res   <= RES_NONE;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            op_a  <= op_a_nxt;
            op_b  <= op_b_nxt;
            res   <= res_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        op_a_nxt  = op_a;
        op_b_nxt  = op_b;
        res_nxt   = res;
        unique case (state)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto offset binary,
                    // so the unsigned digit path orders signed operands correctly.
                    op_a_nxt  = a ^ (is_signed ? SIGN_BIT : '0);
                    op_b_nxt  = b ^ (is_signed ? SIGN_BIT : '0);
                    idx_nxt   = IDX_TOP;
                    res_nxt   = RES_NONE;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (dig_gt) begin
                    res_nxt   = RES_GT;
                    state_nxt = DONE;
                end else if (dig_lt) begin
                    res_nxt   = RES_LT;
                    state_nxt = DONE;
                end else if (idx == '0) begin
                    res_nxt   = RES_EQ;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx - 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == RUN);
        done         = (state == DONE);
        {gt, eq, lt} = res;
    end

endmodule

// File: tb/tb_serial_compare.sv
// Scoreboarded bench for serial_compare: directed vectors on a 10/2 instance plus
// random sweeps on 8/1 and 8/8 instances, all checked by one negedge monitor.
module tb_serial_compare;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    typedef struct {
        logic [2:0] f;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, is_signed;
    logic [9:0] a, b;
    logic       busy, done, gt, eq, lt;

    logic       start8, s8;
    logic [7:0] a8, b8;
    logic       busy81, done81, gt81, eq81, lt81;
    logic       busy88, done88, gt88, eq88, lt88;

    exp_t q10[$], q81[$], q88[$];
    exp_t e10, e81, e88;
    int   c10, c81, c88;
    int   checks, errors;
    logic end_req;

    always #5 clk = ~clk;

    serial_compare #(.WIDTH(10), .DIGIT(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .is_signed(is_signed),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    serial_compare #(.WIDTH(8), .DIGIT(1)) dut81 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .is_signed(s8),
        .busy(busy81), .done(done81), .gt(gt81), .eq(eq81), .lt(lt81)
    );

    serial_compare #(.WIDTH(8), .DIGIT(8)) dut88 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .is_signed(s8),
        .busy(busy88), .done(done88), .gt(gt88), .eq(eq88), .lt(lt88)
    );

    // Reference: flags from native signed/unsigned compare; latency is the
    // 1-based position (from the MSB) of the first differing digit.
    function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y,
                                    input logic s, input int dig);
        exp_t e;
        int   nd, mx, my, m;
        bit   found;
        if (s) begin
            if ($signed(x) > $signed(y))       e.f = F_GT;
            else if ($signed(x) == $signed(y)) e.f = F_EQ;
            else                               e.f = F_LT;
        end else begin
            if (x > y)       e.f = F_GT;
            else if (x == y) e.f = F_EQ;
            else             e.f = F_LT;
        end
        nd    = 8 / dig;
        m     = (1 << dig) - 1;
        mx    = int'(x) ^ (s ? 128 : 0);
        my    = int'(y) ^ (s ? 128 : 0);
        e.lat = nd;
        found = 1'b0;
        for (int i = nd - 1; i >= 0; i--) begin
            if (!found && (((mx >> (i * dig)) & m) != ((my >> (i * dig)) & m))) begin
                e.lat = nd - i;
                found = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic done_chk(input string nm, input int qsz, input exp_t e,
                            input logic [2:0] f, input int c);
        checks++;
        if (qsz == 0) begin
            errors++;
            $display("FAIL %s unexpected_done: got flags=%b lat=%0d, none expected", nm, f, c);
        end else if (f !== e.f || c != e.lat) begin
            errors++;
            $display("FAIL %s result: got flags=%b lat=%0d, want flags=%b lat=%0d",
                     nm, f, c, e.f, e.lat);
        end
    endtask

    task automatic rst_chk(input string nm, input logic [4:0] v);
        checks++;
        if (v !== 5'b0) begin
            errors++;
            $display("FAIL %s reset_outputs: got {busy,done,gt,eq,lt}=%b, want 00000", nm, v);
        end
    endtask

    task automatic q_chk(input string nm, input int sz);
        checks++;
        if (sz != 0) begin
            errors++;
            $display("FAIL %s missing_done: got %0d results outstanding, want 0", nm, sz);
        end
    endtask

    // Single monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            c10 = 0; c81 = 0; c88 = 0;
            rst_chk("w10d2", {busy, done, gt, eq, lt});
            rst_chk("w8d1", {busy81, done81, gt81, eq81, lt81});
            rst_chk("w8d8", {busy88, done88, gt88, eq88, lt88});
        end else begin
            if (busy)   c10++;
            if (busy81) c81++;
            if (busy88) c88++;
            if (done) begin
                e10 = '{f: 3'b000, lat: 0};
                if (q10.size() > 0) begin
                    e10 = q10.pop_front();
                    done_chk("w10d2", 1, e10, {gt, eq, lt}, c10);
                end else done_chk("w10d2", 0, e10, {gt, eq, lt}, c10);
                c10 = 0;
            end
            if (done81) begin
                e81 = '{f: 3'b000, lat: 0};
                if (q81.size() > 0) begin
                    e81 = q81.pop_front();
                    done_chk("w8d1", 1, e81, {gt81, eq81, lt81}, c81);
                end else done_chk("w8d1", 0, e81, {gt81, eq81, lt81}, c81);
                c81 = 0;
            end
            if (done88) begin
                e88 = '{f: 3'b000, lat: 0};
                if (q88.size() > 0) begin
                    e88 = q88.pop_front();
                    done_chk("w8d8", 1, e88, {gt88, eq88, lt88}, c88);
                end else done_chk("w8d8", 0, e88, {gt88, eq88, lt88}, c88);
                c88 = 0;
            end
        end
        if (end_req) begin
            q_chk("w10d2", q10.size());
            q_chk("w8d1", q81.size());
            q_chk("w8d8", q88.size());
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Issue one compare on the 10/2 instance; operands are scrambled right after
    // the accepting edge to show they are not resampled.
    task automatic cmp(input logic [9:0] va, input logic [9:0] vb, input logic s,
                       input logic [2:0] f, input int lat);
        a = va; b = vb; is_signed = s; start = 1'b1;
        q10.push_back('{f: f, lat: lat});
        @(posedge clk);
        #1;
        start = 1'b0; a = ~va; b = ~vb; is_signed = ~s;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; end_req = 1'b0;
        c10 = 0; c81 = 0; c88 = 0;
        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        start8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        cmp(10'h200, 10'h081, 1'b0, F_GT, 1);
        cmp(10'h083, 10'h083, 1'b0, F_EQ, 5);
        cmp(10'h3FF, 10'h3FF, 1'b0, F_EQ, 5);
        cmp(10'h000, 10'h000, 1'b0, F_EQ, 5);
        cmp(10'h002, 10'h005, 1'b0, F_LT, 4);
        cmp(10'h2AA, 10'h155, 1'b0, F_GT, 1);
        cmp(10'h3FF, 10'h001, 1'b1, F_LT, 1);
        cmp(10'h3FF, 10'h001, 1'b0, F_GT, 1);
        cmp(10'h200, 10'h1FF, 1'b1, F_LT, 1);
        cmp(10'h300, 10'h300, 1'b1, F_EQ, 5);
        cmp(10'h3FE, 10'h3FF, 1'b1, F_LT, 5);
        cmp(10'h1FF, 10'h200, 1'b0, F_LT, 1);

        // start held across RUN and DONE: exactly one compare.
        a = 10'h200; b = 10'h081; is_signed = 1'b0; start = 1'b1;
        q10.push_back('{f: F_GT, lat: 1});
        @(posedge clk);
        #1 a = 10'h000; b = 10'h3FF; is_signed = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);

        // Reset mid-RUN of an equal compare: no done, outputs cleared.
        a = 10'h083; b = 10'h083; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cmp(10'h001, 10'h000, 1'b0, F_GT, 5);

        // Sweep on the 8-bit instances, both modes per pair.
        for (int i = 0; i < 500; i++) begin
            for (int m = 0; m < 2; m++) begin
                a8 = 8'($urandom_range(0, 255));
                b8 = (i % 16 == 0) ? a8 : 8'($urandom_range(0, 255));
                if (m == 1 && i % 16 == 8) b8 = a8 ^ 8'h01;
                s8 = m[0];
                start8 = 1'b1;
                q81.push_back(model8(a8, b8, s8, 1));
                q88.push_back(model8(a8, b8, s8, 8));
                @(posedge clk);
                #1 start8 = 1'b0; a8 = ~a8; s8 = ~s8;
                repeat (11) @(negedge clk);
            end
        end

        end_req = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule
